tinyqv_issue_ctrl: RTL and testbench
====================================

Name: tinyqv_issue_ctrl

Overview:
Issue sequencer sitting between the instruction decoder and tinyqv_core.
- Owns the free-running 3-bit sub-cycle counter and the architectural PC.
- Buffers decoded instructions in a 2-entry queue and presents one instruction slot per instruction boundary.
- Injects stall slots when starved and interrupt slots when an enabled IRQ is pending.
- Streams pc/next_pc nibbles to the core and handles branch redirect/flush.

Parameters:
BUNDLE_W, 48, width of the opaque decoded-instruction bundle (fields the core consumes)
ADDR_W, 24, PC width in bits; bit 0 is always 0
NUM_IRQ, 4, number of level-sensitive interrupt inputs
RESET_PC, 24'h000000, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
dec_valid  in  1  decoder offers an instruction
dec_ready  out  1  queue can accept; push when dec_valid && dec_ready
dec_bundle  in  BUNDLE_W  decoded instruction
dec_len2  in  1  1 = compressed (2-byte) instruction, 0 = 4-byte
instr_complete  in  1  from core; valid only when counter==7
branch  in  1  from core; redirect at this boundary
branch_addr  in  ADDR_W  redirect target, valid with branch
mret  in  1  current slot is MRET; re-enables interrupts at its boundary
mie_set  in  1  one-cycle pulse: set global interrupt enable
irq  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  per-line enable
counter  out  3  sub-cycle counter to core
slot_bundle  out  BUNDLE_W  current instruction bundle; all-zero when stall/interrupt
slot_is_stall  out  1  current slot is a stall (NOP, 1 pass)
slot_is_interrupt  out  1  current slot is an interrupt entry
irq_cause  out  5  cause for interrupt slot: 16 + lowest pending index
pc_nibble  out  4  nibble [counter] of zero-extended 32-bit PC
next_pc_nibble  out  4  nibble [counter] of PC + slot length
flush  out  1  one-cycle pulse: fetch must restart at fetch_addr
fetch_addr  out  ADDR_W  current PC (restart address when flush)

Behaviour:
- Reset values: counter=0, queue empty, slot=stall (slot_is_stall=1, bundle 0, is_interrupt=0, irq_cause=0), pc=RESET_PC, mie=0, flush=0, next-pc carry=0.
- Reset asserted mid-slot discards everything; no partial state survives.
- counter increments every clock, 7 wraps to 0; never stalls.
- Boundary = counter==7 && instr_complete; the slot changes on that edge. Core must complete stall slots in one pass.
- Boundary priority: branch > interrupt > pop > stall.
- Branch at boundary:
  - pc <= branch_addr; queue cleared, including any push in that same cycle.
  - next slot = stall; flush=1 for exactly the following cycle (counter==0).
  - dec_ready=0 during the flush cycle.
- Interrupt:
  - pending = mie && |(irq & irq_mask), sampled at boundary.
  - Taken if no branch: next slot is_interrupt=1, irq_cause latched, mie <= 0, pc unchanged, queue cleared.
  - The core branches to the vector at the end of the interrupt slot (normal branch path).
- Pop: queue non-empty, no branch/interrupt → head becomes slot; pc <= pc + (current slot len2 ? 2 : 4).
  - Stall and interrupt slots never advance pc.
- Empty queue at boundary with no branch/interrupt → stall slot; pc advanced as for pop if the retiring slot was a real instruction.
- mret at boundary: mie <= 1 (also on mie_set pulse); mret also implies branch from the core.
- Queue: 2 entries {bundle, len2}.
  - dec_ready = count<2 && !flush; push and pop in same cycle allowed.
  - Full stays full until pop; no overflow or underflow possible.
- pc_nibble = {zero-extended pc}[4*counter+:4].
- next_pc_nibble is a serial add with carry register: counter 0 adds len (2/4) to nibble 0; later counters add carry; carry cleared at counter 0.
  - Wraps mod 2^ADDR_W; upper nibbles beyond ADDR_W are 0.
- Boundary without instr_complete: slot and pc held; the slot repeats for another pass.

Decomposition:
- Package tinyqv_issue_pkg: IRQ_CAUSE_BASE=16, slot-kind enum {SLOT_INSTR, SLOT_STALL, SLOT_IRQ}, queue depth constant.
- Sub-module tinyqv_issue_fifo: 2-entry FIFO with synchronous clear, push/pop/full/empty.

Test Plan:
- Reset release, dec_valid=0, instr_complete at every counter==7 → stall slots repeat, pc stays 0x000000, counter cycles 0..7.
- Push 4-byte then 2-byte instruction from pc=0x000100, complete each pass → slots issue in order; pc 0x100→0x104→0x106; next_pc_nibble at counter 0 reads 4, then 6.
- Queue full (2 entries), dec_valid held → dec_ready=0; a boundary pop and a push in the same cycle keep count=2 with order preserved.
- branch with branch_addr=0x0012A0 while 2 entries queued → queue cleared, flush=1 at next counter 0, fetch_addr=0x0012A0, next slot stall.
- mie_set, irq=4'b0110, mask=4'b0100 at boundary → interrupt slot, irq_cause=18, mie=0; second irq ignored until mret boundary restores mie.
- rst asserted at counter=3 with full queue → immediately counter=0, queue empty, pc=RESET_PC, slot stall.

Source files
------------

// File: rtl/tinyqv_issue_pkg.sv
// Shared constants, slot-kind encoding and helpers for the tinyqv issue sequencer.
package tinyqv_issue_pkg;

    localparam int unsigned DEF_BUNDLE_W   = 48;
    localparam int unsigned DEF_ADDR_W     = 24;
    localparam int unsigned DEF_NUM_IRQ    = 4;
    localparam int unsigned IRQ_CAUSE_BASE = 16;
    localparam int unsigned QUEUE_DEPTH    = 2;
    localparam int unsigned CAUSE_W        = 5;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic [1:0] {
        SLOT_INSTR = 2'd0,
        SLOT_STALL = 2'd1,
        SLOT_IRQ   = 2'd2
    } slot_kind_e;

    // Interrupt cause for the lowest-numbered pending line (0 when none pending).
    function automatic logic [CAUSE_W-1:0] lowest_cause(input logic [31:0] pend);
        logic [CAUSE_W-1:0] cause;
        cause = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pend[i]) begin
                cause = CAUSE_W'(IRQ_CAUSE_BASE + 32'(i));
            end
        end
        return cause;
    endfunction

endpackage

// File: rtl/tinyqv_issue_ctrl_if.sv
// Decoder-side and core-side signals of the issue sequencer.
interface tinyqv_issue_ctrl_if #(
    parameter int unsigned BUNDLE_W = tinyqv_issue_pkg::DEF_BUNDLE_W,
    parameter int unsigned ADDR_W   = tinyqv_issue_pkg::DEF_ADDR_W,
    parameter int unsigned NUM_IRQ  = tinyqv_issue_pkg::DEF_NUM_IRQ
);

    logic                dec_valid;
    logic                dec_ready;
    logic [BUNDLE_W-1:0] dec_bundle;
    logic                dec_len2;
    logic                instr_complete;
    logic                branch;
    logic [ADDR_W-1:0]   branch_addr;
    logic                mret;
    logic                mie_set;
    logic [NUM_IRQ-1:0]  irq;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic [2:0]          counter;
    logic [BUNDLE_W-1:0] slot_bundle;
    logic                slot_is_stall;
    logic                slot_is_interrupt;
    logic [4:0]          irq_cause;
    logic [3:0]          pc_nibble;
    logic [3:0]          next_pc_nibble;
    logic                flush;
    logic [ADDR_W-1:0]   fetch_addr;

    // The issue sequencer itself.
    modport slave (
        input  dec_valid, dec_bundle, dec_len2, instr_complete, branch, branch_addr,
               mret, mie_set, irq, irq_mask,
        output dec_ready, counter, slot_bundle, slot_is_stall, slot_is_interrupt,
               irq_cause, pc_nibble, next_pc_nibble, flush, fetch_addr
    );

    // Decoder plus core environment driving the sequencer.
    modport master (
        output dec_valid, dec_bundle, dec_len2, instr_complete, branch, branch_addr,
               mret, mie_set, irq, irq_mask,
        input  dec_ready, counter, slot_bundle, slot_is_stall, slot_is_interrupt,
               irq_cause, pc_nibble, next_pc_nibble, flush, fetch_addr
    );

endinterface

// File: rtl/tinyqv_issue_fifo.sv
// Two-entry instruction queue with synchronous clear; push/pop guarded against overflow/underflow.
module tinyqv_issue_fifo
    import tinyqv_issue_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [QUEUE_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(QUEUE_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; clear wins over a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tinyqv_issue_ctrl.sv
// Issue sequencer: sub-cycle counter, PC, instruction queue, stall/interrupt slot injection,
// branch redirect/flush and serial pc/next_pc nibble streaming to the core.
module tinyqv_issue_ctrl
    import tinyqv_issue_pkg::*;
#(
    parameter int unsigned     BUNDLE_W = DEF_BUNDLE_W,
    parameter int unsigned     ADDR_W   = DEF_ADDR_W,
    parameter int unsigned     NUM_IRQ  = DEF_NUM_IRQ,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    tinyqv_issue_ctrl_if.slave bus
);

    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    slot_kind_e          state_q;
    slot_kind_e          state_d;
    logic [CNT_W-1:0]    counter_q;
    logic [BUNDLE_W-1:0] bundle_q;
    logic [BUNDLE_W-1:0] bundle_d;
    logic                len2_q;
    logic                len2_d;
    logic [CAUSE_W-1:0]  cause_q;
    logic [CAUSE_W-1:0]  cause_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                mie_q;
    logic                mie_d;
    logic                flush_q;
    logic                flush_d;
    logic                carry_q;
    logic                carry_d;

    logic                dec_ready;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_clr;
    logic [BUNDLE_W:0]   fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;

    logic                boundary;
    logic [31:0]         pend;
    logic                irq_pending;
    logic                take_irq;
    logic [ADDR_W-1:0]   pc_step;

    logic [31:0]         pc_ext;
    logic [4:0]          nib_idx;
    logic [3:0]          pc_nib;
    logic [3:0]          mask_nib;
    logic [4:0]          nib_addend;
    logic [4:0]          nib_sum;

    assign boundary    = (counter_q == CNT_W'(7)) && bus.instr_complete;
    assign pend        = 32'(bus.irq & bus.irq_mask);
    assign irq_pending = mie_q && (pend != 32'd0);
    assign take_irq    = boundary && !bus.branch && irq_pending;
    assign pc_step     = ADDR_W'(len2_q ? 3'd2 : 3'd4);

    assign dec_ready = !fifo_full && !flush_q;
    assign fifo_push = bus.dec_valid && dec_ready;

    tinyqv_issue_fifo #(
        .W (BUNDLE_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.dec_len2, bus.dec_bundle}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serial pc + length: slot length enters at nibble 0, later nibbles only take the carry.
    assign pc_ext     = 32'(pc_q);
    assign nib_idx    = {counter_q, 2'b00};
    assign pc_nib     = pc_ext[nib_idx +: 4];
    assign mask_nib   = ADDR_MASK[nib_idx +: 4];
    assign nib_addend = (counter_q == '0) ? (len2_q ? 5'd2 : 5'd4) : {4'd0, carry_q};
    assign nib_sum    = {1'b0, pc_nib} + nib_addend;
    assign carry_d    = nib_sum[4];

    // Next slot selection at the instruction boundary: branch > interrupt > pop > stall.
    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        len2_d   = len2_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        mie_d    = mie_q;
        flush_d  = 1'b0;
        fifo_pop = 1'b0;
        fifo_clr = 1'b0;

        if (boundary) begin
            if (bus.branch) begin
                state_d  = SLOT_STALL;
                bundle_d = '0;
                len2_d   = 1'b0;
                cause_d  = '0;
                pc_d     = bus.branch_addr;
                fifo_clr = 1'b1;
                flush_d  = 1'b1;
            end else if (irq_pending) begin
                state_d  = SLOT_IRQ;
                bundle_d = '0;
                len2_d   = 1'b0;
                cause_d  = lowest_cause(pend);
                fifo_clr = 1'b1;
            end else begin
                if (state_q == SLOT_INSTR) begin
                    pc_d = pc_q + pc_step;
                end
                if (!fifo_empty) begin
                    state_d  = SLOT_INSTR;
                    fifo_pop = 1'b1;
                    bundle_d = fifo_dout[BUNDLE_W-1:0];
                    len2_d   = fifo_dout[BUNDLE_W];
                    cause_d  = '0;
                end else begin
                    state_d  = SLOT_STALL;
                    bundle_d = '0;
                    len2_d   = 1'b0;
                    cause_d  = '0;
                end
            end
        end

        if (take_irq) begin
            mie_d = 1'b0;
        end else if (bus.mie_set || (boundary && bus.mret)) begin
            mie_d = 1'b1;
        end
    end

    // Slot state, PC, interrupt enable and free-running counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SLOT_STALL;
            counter_q <= '0;
            bundle_q  <= '0;
            len2_q    <= 1'b0;
            cause_q   <= '0;
            pc_q      <= RESET_PC;
            mie_q     <= 1'b0;
            flush_q   <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_q + CNT_W'(1);
            bundle_q  <= bundle_d;
            len2_q    <= len2_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            mie_q     <= mie_d;
            flush_q   <= flush_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.dec_ready         = dec_ready;
    assign bus.counter           = counter_q;
    assign bus.slot_bundle       = bundle_q;
    assign bus.slot_is_stall     = (state_q == SLOT_STALL);
    assign bus.slot_is_interrupt = (state_q == SLOT_IRQ);
    assign bus.irq_cause         = cause_q;
    assign bus.pc_nibble         = pc_nib;
    assign bus.next_pc_nibble    = nib_sum[3:0] & mask_nib;
    assign bus.flush             = flush_q;
    assign bus.fetch_addr        = pc_q;

endmodule

// File: tb/tb_tinyqv_issue_ctrl.sv
// Directed bench for tinyqv_issue_ctrl: slot-by-slot vector table plus multi-cycle sequences.
module tb_tinyqv_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tinyqv_issue_ctrl_if bus ();

    tinyqv_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    localparam logic [47:0] BA = 48'hA0A0_0000_0001;
    localparam logic [47:0] BB = 48'hB0B0_0000_0002;
    localparam logic [47:0] BC = 48'h0C0C_0000_0003;
    localparam logic [47:0] BD = 48'h0D0D_0000_0004;
    localparam logic [47:0] E1 = 48'h1111_2222_3331;
    localparam logic [47:0] E2 = 48'h1111_2222_3332;
    localparam logic [47:0] E3 = 48'h1111_2222_3333;
    localparam logic [47:0] E4 = 48'h1111_2222_3334;

    typedef struct {
        logic        push;
        logic        len2;
        logic [47:0] bundle;
        logic        mie_set;
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        br;
        logic [23:0] addr;
        logic        mret;
        logic        cmp;
        logic        e_stall;
        logic        e_irq;
        logic [47:0] e_bundle;
        logic [4:0]  e_cause;
        logic [23:0] e_pc;
        logic        e_flush;
        logic        e_ready;
        logic [3:0]  e_pcn;
        logic [3:0]  e_npc;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic push, input logic len2, input logic [47:0] bundle, input logic mie_set,
        input logic [3:0] irq, input logic [3:0] mask, input logic br, input logic [23:0] addr,
        input logic mret, input logic cmp, input logic e_stall, input logic e_irq,
        input logic [47:0] e_bundle, input logic [4:0] e_cause, input logic [23:0] e_pc,
        input logic e_flush, input logic e_ready, input logic [3:0] e_pcn, input logic [3:0] e_npc);
        vec_t v;
        v.push = push; v.len2 = len2; v.bundle = bundle; v.mie_set = mie_set;
        v.irq = irq; v.mask = mask; v.br = br; v.addr = addr; v.mret = mret; v.cmp = cmp;
        v.e_stall = e_stall; v.e_irq = e_irq; v.e_bundle = e_bundle; v.e_cause = e_cause;
        v.e_pc = e_pc; v.e_flush = e_flush; v.e_ready = e_ready; v.e_pcn = e_pcn; v.e_npc = e_npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [2:0] n, input string tag);
        int guard;
        guard = 0;
        while (bus.counter !== n && guard < 16) begin
            tick();
            guard++;
        end
        if (bus.counter !== n) begin
            total++;
            bad++;
            $display("FAIL %s: counter %0h never reached %0h", tag, bus.counter, n);
        end
    endtask

    task automatic clear_inputs();
        bus.dec_valid      = 1'b0;
        bus.dec_bundle     = '0;
        bus.dec_len2       = 1'b0;
        bus.instr_complete = 1'b0;
        bus.branch         = 1'b0;
        bus.branch_addr    = '0;
        bus.mret           = 1'b0;
        bus.mie_set        = 1'b0;
        bus.irq            = '0;
        bus.irq_mask       = '0;
    endtask

    task automatic push_one(input logic [47:0] b, input logic l2);
        bus.dec_valid  = 1'b1;
        bus.dec_bundle = b;
        bus.dec_len2   = l2;
        tick();
        bus.dec_valid  = 1'b0;
    endtask

    // Complete the current slot at the next counter==7, optionally with branch or irq lines.
    task automatic boundary(input logic br, input logic [23:0] addr,
                            input logic [3:0] irqv, input logic [3:0] maskv);
        wait_cnt(3'd7, "bnd_wait");
        bus.instr_complete = 1'b1;
        bus.branch         = br;
        bus.branch_addr    = addr;
        bus.irq            = irqv;
        bus.irq_mask       = maskv;
        tick();
        bus.instr_complete = 1'b0;
        bus.branch         = 1'b0;
        bus.branch_addr    = '0;
        bus.irq            = '0;
        bus.irq_mask       = '0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        wait_cnt(3'd1, $sformatf("v%0d_w1", k));
        bus.mie_set = v.mie_set;
        tick();
        bus.mie_set = 1'b0;
        if (v.push) push_one(v.bundle, v.len2);
        else tick();
        wait_cnt(3'd7, $sformatf("v%0d_w7", k));
        bus.instr_complete = v.cmp;
        bus.branch         = v.br;
        bus.branch_addr    = v.addr;
        bus.mret           = v.mret;
        bus.irq            = v.irq;
        bus.irq_mask       = v.mask;
        tick();
        clear_inputs();
        chk($sformatf("v%0d_counter", k), 64'(bus.counter), 64'd0);
        chk($sformatf("v%0d_stall", k), 64'(bus.slot_is_stall), 64'(v.e_stall));
        chk($sformatf("v%0d_intr", k), 64'(bus.slot_is_interrupt), 64'(v.e_irq));
        chk($sformatf("v%0d_bundle", k), 64'(bus.slot_bundle), 64'(v.e_bundle));
        chk($sformatf("v%0d_cause", k), 64'(bus.irq_cause), 64'(v.e_cause));
        chk($sformatf("v%0d_pc", k), 64'(bus.fetch_addr), 64'(v.e_pc));
        chk($sformatf("v%0d_flush", k), 64'(bus.flush), 64'(v.e_flush));
        chk($sformatf("v%0d_ready", k), 64'(bus.dec_ready), 64'(v.e_ready));
        chk($sformatf("v%0d_pcn0", k), 64'(bus.pc_nibble), 64'(v.e_pcn));
        chk($sformatf("v%0d_npc0", k), 64'(bus.next_pc_nibble), 64'(v.e_npc));
    endtask

    // Check all eight pc / next_pc nibbles of the current slot, starting at counter 0.
    task automatic chk_stream(input string tag, input logic [31:0] epc, input logic [31:0] enpc);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_pcn%0d", tag, i), 64'(bus.pc_nibble), 64'(epc[4*i +: 4]));
            chk($sformatf("%s_npc%0d", tag, i), 64'(bus.next_pc_nibble), 64'(enpc[4*i +: 4]));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            push len2 bundle mie irq    mask   br addr      mret cmp | stall intr bundle cause pc      flush rdy pcn  npc
        vecs[0]  = mk(0, 0, '0, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  1, 0, '0, 5'd0,  24'h000000, 0, 1, 4'h0, 4'h4);
        vecs[1]  = mk(1, 0, BA, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  0, 0, BA, 5'd0,  24'h000000, 0, 1, 4'h0, 4'h4);
        vecs[2]  = mk(1, 1, BB, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  0, 0, BB, 5'd0,  24'h000004, 0, 1, 4'h4, 4'h6);
        vecs[3]  = mk(0, 0, '0, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  1, 0, '0, 5'd0,  24'h000006, 0, 1, 4'h6, 4'hA);
        vecs[4]  = mk(0, 0, '0, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 0,  1, 0, '0, 5'd0,  24'h000006, 0, 1, 4'h6, 4'hA);
        vecs[5]  = mk(0, 0, '0, 0, 4'b0000, 4'b0000, 1, 24'h000100, 0, 1, 1, 0, '0, 5'd0,  24'h000100, 1, 0, 4'h0, 4'h4);
        vecs[6]  = mk(1, 0, BC, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  0, 0, BC, 5'd0,  24'h000100, 0, 1, 4'h0, 4'h4);
        vecs[7]  = mk(1, 1, BD, 0, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  0, 0, BD, 5'd0,  24'h000104, 0, 1, 4'h4, 4'h6);
        vecs[8]  = mk(0, 0, '0, 1, 4'b0000, 4'b0000, 0, 24'h0,     0, 1,  1, 0, '0, 5'd0,  24'h000106, 0, 1, 4'h6, 4'hA);
        vecs[9]  = mk(0, 0, '0, 0, 4'b0110, 4'b0100, 0, 24'h0,     0, 1,  0, 1, '0, 5'd18, 24'h000106, 0, 1, 4'h6, 4'hA);
        vecs[10] = mk(0, 0, '0, 0, 4'b0110, 4'b0110, 0, 24'h0,     0, 1,  1, 0, '0, 5'd0,  24'h000106, 0, 1, 4'h6, 4'hA);
        vecs[11] = mk(0, 0, '0, 0, 4'b0000, 4'b0000, 1, 24'h0012A0, 1, 1, 1, 0, '0, 5'd0,  24'h0012A0, 1, 0, 4'h0, 4'h4);
        vecs[12] = mk(0, 0, '0, 0, 4'b1000, 4'b1111, 0, 24'h0,     0, 1,  0, 1, '0, 5'd19, 24'h0012A0, 0, 1, 4'h0, 4'h4);

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_counter", 64'(bus.counter), 64'd0);
        chk("rst_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("rst_intr", 64'(bus.slot_is_interrupt), 64'd0);
        chk("rst_bundle", 64'(bus.slot_bundle), 64'd0);
        chk("rst_cause", 64'(bus.irq_cause), 64'd0);
        chk("rst_pc", 64'(bus.fetch_addr), 64'd0);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_ready", 64'(bus.dec_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cnt_seq%0d", i), 64'(bus.counter), 64'(i));
            tick();
        end

        for (int k = 0; k < NV; k++) begin
            run_vec(k);
        end

        // Nibble stream of the interrupt slot at pc 0x0012A0.
        chk_stream("irqslot", 32'h0000_12A0, 32'h0000_12A4);

        // Carry chain and wrap at the top of the address space.
        boundary(1'b1, 24'hFFFFFE, 4'b0, 4'b0);
        chk("wrap_pc", 64'(bus.fetch_addr), 64'hFFFFFE);
        chk_stream("wrap", 32'h00FF_FFFE, 32'h0000_0002);

        // Full queue, refill after pop, push+pop in the same boundary cycle.
        boundary(1'b1, 24'h000200, 4'b0, 4'b0);
        tick();
        bus.dec_valid  = 1'b1;
        bus.dec_len2   = 1'b0;
        bus.dec_bundle = E1;
        tick();
        bus.dec_bundle = E2;
        tick();
        chk("full_ready", 64'(bus.dec_ready), 64'd0);
        bus.dec_bundle = E3;
        wait_cnt(3'd7, "full_w7");
        bus.instr_complete = 1'b1;
        tick();
        bus.instr_complete = 1'b0;
        chk("q_slot1", 64'(bus.slot_bundle), 64'(E1));
        chk("q_pc1", 64'(bus.fetch_addr), 64'h200);
        chk("q_ready_after_pop", 64'(bus.dec_ready), 64'd1);
        tick();
        chk("q_refill_ready", 64'(bus.dec_ready), 64'd0);
        bus.dec_valid = 1'b0;
        boundary(1'b0, 24'h0, 4'b0, 4'b0);
        chk("q_slot2", 64'(bus.slot_bundle), 64'(E2));
        chk("q_pc2", 64'(bus.fetch_addr), 64'h204);
        chk("q_ready2", 64'(bus.dec_ready), 64'd1);
        wait_cnt(3'd7, "pp_w7");
        bus.dec_valid      = 1'b1;
        bus.dec_bundle     = E4;
        bus.instr_complete = 1'b1;
        tick();
        bus.dec_valid      = 1'b0;
        bus.instr_complete = 1'b0;
        chk("q_slot3", 64'(bus.slot_bundle), 64'(E3));
        chk("q_pc3", 64'(bus.fetch_addr), 64'h208);
        chk("q_ready3", 64'(bus.dec_ready), 64'd1);
        boundary(1'b0, 24'h0, 4'b0, 4'b0);
        chk("q_slot4", 64'(bus.slot_bundle), 64'(E4));
        chk("q_pc4", 64'(bus.fetch_addr), 64'h20C);
        boundary(1'b0, 24'h0, 4'b0, 4'b0);
        chk("q_drain_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("q_drain_bundle", 64'(bus.slot_bundle), 64'd0);
        chk("q_drain_pc", 64'(bus.fetch_addr), 64'h210);

        // Branch with a full queue: flush for exactly one cycle, queue discarded.
        tick();
        push_one(E1, 1'b0);
        push_one(E2, 1'b0);
        chk("br_full_ready", 64'(bus.dec_ready), 64'd0);
        boundary(1'b1, 24'h0012A0, 4'b0, 4'b0);
        chk("br_flush", 64'(bus.flush), 64'd1);
        chk("br_fetch", 64'(bus.fetch_addr), 64'h0012A0);
        chk("br_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("br_ready_flush", 64'(bus.dec_ready), 64'd0);
        tick();
        chk("br_flush_end", 64'(bus.flush), 64'd0);
        chk("br_ready_cleared", 64'(bus.dec_ready), 64'd1);
        boundary(1'b0, 24'h0, 4'b0, 4'b0);
        chk("br_next_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("br_next_pc", 64'(bus.fetch_addr), 64'h0012A0);

        // Branch drops a push made in the same cycle.
        tick();
        push_one(E3, 1'b0);
        wait_cnt(3'd7, "brp_w7");
        bus.dec_valid      = 1'b1;
        bus.dec_bundle     = E4;
        bus.instr_complete = 1'b1;
        bus.branch         = 1'b1;
        bus.branch_addr    = 24'h000300;
        tick();
        clear_inputs();
        chk("brp_fetch", 64'(bus.fetch_addr), 64'h000300);
        boundary(1'b0, 24'h0, 4'b0, 4'b0);
        chk("brp_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("brp_bundle", 64'(bus.slot_bundle), 64'd0);

        // Asynchronous reset at counter 3 with a full queue and mie set.
        bus.mie_set = 1'b1;
        tick();
        bus.mie_set = 1'b0;
        push_one(E1, 1'b0);
        push_one(E2, 1'b1);
        wait_cnt(3'd3, "rst_w3");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_counter", 64'(bus.counter), 64'd0);
        chk("arst_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("arst_bundle", 64'(bus.slot_bundle), 64'd0);
        chk("arst_pc", 64'(bus.fetch_addr), 64'd0);
        chk("arst_ready", 64'(bus.dec_ready), 64'd1);
        chk("arst_flush", 64'(bus.flush), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("arst_counter2", 64'(bus.counter), 64'd0);
        boundary(1'b0, 24'h0, 4'b0001, 4'b0001);
        chk("arst_no_irq", 64'(bus.slot_is_interrupt), 64'd0);
        chk("arst_empty_stall", 64'(bus.slot_is_stall), 64'd1);
        chk("arst_pc2", 64'(bus.fetch_addr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
